regfile_sb: RTL and testbench

Parametrised multi-read-port register file with a built-in write-pending scoreboard. It replaces the single-write, two-read register file in the decode stage of the MIPS-lite core. Reads are registered. Each read port also returns a busy flag, so hazard logic can stall on registers with an outstanding write. Register 0 is hardwired to zero.

---
 rtl/regfile_sb_pkg.sv | 12 +
 rtl/regfile_scoreboard.sv | 36 +++
 rtl/regfile_sb.sv | 93 +++++++++
 tb/tb_regfile_sb.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_sb_pkg.sv
// Shared constants for the decode-stage register file, so the core and the bench agree.
// Reset/zero value, hardwired-zero register address and default geometry.
package regfile_sb_pkg;

   localparam logic [31:0] INITIAL_VAL_32 = 32'h0000_0000;
   localparam logic [4:0]  ZERO_REG       = 5'd0;

   localparam int DEFAULT_DATA_W = 32;
   localparam int DEFAULT_ADDR_W = 5;
   localparam int DEFAULT_NUM_RD = 2;

endpackage

// File: rtl/regfile_scoreboard.sv
// Write-pending scoreboard: one busy bit per register, issue sets, write clears, set wins.
// Exposes both the registered busy vector and its next state for the bypass path.
module regfile_scoreboard
   import regfile_sb_pkg::*;
#(
   parameter int ADDR_W = DEFAULT_ADDR_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wen,
   input  logic [ADDR_W-1:0]      wr_addr,
   input  logic                   iss_en,
   input  logic [ADDR_W-1:0]      iss_addr,
   output logic [2**ADDR_W-1:0]   busy,
   output logic [2**ADDR_W-1:0]   busy_nxt
);

   always_comb begin
      // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
      busy_nxt = busy;
      if (wen)
         busy_nxt[wr_addr] = 1'b0;
      if (iss_en && iss_addr != ADDR_W'(ZERO_REG))
         busy_nxt[iss_addr] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!rst_n)
         busy <= '0;
      else
         busy <= busy_nxt;
   end

endmodule

// File: rtl/regfile_sb.sv
// Flop-based register file with NUM_RD registered read ports and per-port busy flags.
// Define REGFILE_BYPASS_EN to forward same-cycle write data/busy to a matching read.
module regfile_sb
   import regfile_sb_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int ADDR_W = DEFAULT_ADDR_W,
   parameter int NUM_RD = DEFAULT_NUM_RD
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wen,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     iss_en,
   input  logic [ADDR_W-1:0]        iss_addr,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  busy_nxt;

   regfile_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .wen      (wen),
      .wr_addr  (wr_addr),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .busy     (busy),
      .busy_nxt (busy_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the storage array is reset because the core relies on every register reading zero after reset.
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= DATA_W'(INITIAL_VAL_32);
      end else if (wen && wr_addr != ADDR_W'(ZERO_REG)) begin
         mem[wr_addr] <= wr_data;
      end
   end

`ifndef REGFILE_BYPASS_EN
   // Without bypass the next-state busy vector has no consumer here.
   logic unused_busy_nxt;
   assign unused_busy_nxt = ^busy_nxt;
`endif

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] word_sel;
      logic              busy_sel;
      logic [DATA_W-1:0] data_q;
      logic              busy_q;

      assign addr = rd_addr[k*ADDR_W +: ADDR_W];

      always_comb begin
         word_sel = mem[addr];
         busy_sel = busy[addr];
`ifdef REGFILE_BYPASS_EN
         if (wen && wr_addr == addr) begin
            word_sel = wr_data;
            busy_sel = busy_nxt[addr];
         end
`endif
         if (addr == ADDR_W'(ZERO_REG)) begin
            word_sel = DATA_W'(INITIAL_VAL_32);
            busy_sel = 1'b0;
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            data_q <= DATA_W'(INITIAL_VAL_32);
            busy_q <= 1'b0;
         end else begin
            data_q <= word_sel;
            busy_q <= busy_sel;
         end
      end

      assign rd_data[k*DATA_W +: DATA_W] = data_q;
      assign rd_busy[k]                  = busy_q;
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb with three read ports; expectations follow REGFILE_BYPASS_EN.
module tb_regfile_sb;
   import regfile_sb_pkg::*;

   localparam int DW = DEFAULT_DATA_W;
   localparam int AW = DEFAULT_ADDR_W;
   localparam int NR = 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             wen;
   logic [AW-1:0]    wr_addr;
   logic [DW-1:0]    wr_data;
   logic             iss_en;
   logic [AW-1:0]    iss_addr;
   logic [NR*AW-1:0] rd_addr;
   logic [NR*DW-1:0] rd_data;
   logic [NR-1:0]    rd_busy;

   int checks = 0;
   int errors = 0;

   regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wen      (wen),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_busy  (rd_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] port_data(input int k);
      return rd_data[k*DW +: DW];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
      rd_addr = {a2, a1, a0};
   endtask

   task automatic idle();
      wen    = 1'b0;
      iss_en = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; wen = 1'b0; wr_addr = '0; wr_data = '0;
      iss_en = 1'b0; iss_addr = '0; rd_addr = '0;

      // Reset: outputs held at zero, then read 0, 1, 31 after release.
      set_rd(5'd0, 5'd1, 5'd31);
      tick(); tick();
      check("in_reset_data", rd_data[DW-1:0], '0);
      check("in_reset_busy", DW'(rd_busy), '0);
      rst_n = 1'b1;
      tick();
      check("rst_p0_r0", port_data(0), '0);
      check("rst_p1_r1", port_data(1), '0);
      check("rst_p2_r31", port_data(2), '0);
      check("rst_busy", DW'(rd_busy), '0);

      // Write r5, read next cycle.
      wen = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
      tick(); idle();
      set_rd(5'd5, 5'd0, 5'd0);
      tick();
      check("r5_data", port_data(0), 32'hDEAD_BEEF);
      check("r5_busy", DW'(rd_busy[0]), '0);

      // Write to r0 is discarded.
      wen = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234_5678;
      tick(); idle();
      set_rd(5'd0, 5'd0, 5'd0);
      tick();
      check("r0_data", port_data(0), '0);

      // Issue r7 -> busy.
      iss_en = 1'b1; iss_addr = 5'd7;
      tick(); idle();
      set_rd(5'd7, 5'd7, 5'd0);
      tick();
      check("r7_iss_busy_p0", DW'(rd_busy[0]), 1);
      check("r7_iss_busy_p1", DW'(rd_busy[1]), 1);

      // Write r7 clears busy.
      wen = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5_A5A5;
      set_rd(5'd0, 5'd0, 5'd0);
      tick(); idle();
      set_rd(5'd7, 5'd0, 5'd0);
      tick();
      check("r7_wr_data", port_data(0), 32'hA5A5_A5A5);
      check("r7_wr_busy", DW'(rd_busy[0]), 0);

      // Same-cycle issue and write on r7: data written, busy set.
      wen = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_003C;
      iss_en = 1'b1; iss_addr = 5'd7;
      set_rd(5'd0, 5'd0, 5'd0);
      tick(); idle();
      set_rd(5'd7, 5'd0, 5'd0);
      tick();
      check("r7_set_wins_data", port_data(0), 32'h3C);
      check("r7_set_wins_busy", DW'(rd_busy[0]), 1);

      // r9 = 0x11, not busy; then write 0x55 while reading r9.
      wen = 1'b1; wr_addr = 5'd9; wr_data = 32'h11;
      set_rd(5'd0, 5'd0, 5'd0);
      tick();
      wr_data = 32'h55;
      set_rd(5'd9, 5'd9, 5'd0);
      tick(); idle();
`ifdef REGFILE_BYPASS_EN
      check("byp_r9_data", port_data(0), 32'h55);
      check("byp_r9_data_p1", port_data(1), 32'h55);
`else
      check("nobyp_r9_data", port_data(0), 32'h11);
      check("nobyp_r9_data_p1", port_data(1), 32'h11);
`endif
      check("r9_busy", DW'(rd_busy[0]), 0);

      // Old busy = 1: issue r9, then write 0x66 while reading r9.
      iss_en = 1'b1; iss_addr = 5'd9;
      set_rd(5'd0, 5'd0, 5'd0);
      tick(); idle();
      wen = 1'b1; wr_addr = 5'd9; wr_data = 32'h66;
      set_rd(5'd9, 5'd0, 5'd0);
      tick(); idle();
`ifdef REGFILE_BYPASS_EN
      check("byp_busy_clr_data", port_data(0), 32'h66);
      check("byp_busy_clr_busy", DW'(rd_busy[0]), 0);
`else
      check("nobyp_old_busy_data", port_data(0), 32'h55);
      check("nobyp_old_busy_busy", DW'(rd_busy[0]), 1);
`endif

      // Write 0x77 plus same-address issue while reading r9.
      wen = 1'b1; wr_addr = 5'd9; wr_data = 32'h77;
      iss_en = 1'b1; iss_addr = 5'd9;
      tick(); idle();
`ifdef REGFILE_BYPASS_EN
      check("byp_iss_data", port_data(0), 32'h77);
      check("byp_iss_busy", DW'(rd_busy[0]), 1);
`else
      check("nobyp_iss_data", port_data(0), 32'h66);
      check("nobyp_iss_busy", DW'(rd_busy[0]), 0);
`endif
      tick();
      check("r9_after_data", port_data(0), 32'h77);
      check("r9_after_busy", DW'(rd_busy[0]), 1);

      // Multi-port: r3 = 0x77 on ports 0 and 1, r0 on port 2.
      wen = 1'b1; wr_addr = 5'd3; wr_data = 32'h77;
      set_rd(5'd0, 5'd0, 5'd0);
      tick(); idle();
      set_rd(5'd3, 5'd3, 5'd0);
      tick();
      check("mp_p0", port_data(0), 32'h77);
      check("mp_p1", port_data(1), 32'h77);
      check("mp_p2", port_data(2), '0);
      check("mp_busy_idle", DW'(rd_busy), 0);
      iss_en = 1'b1; iss_addr = 5'd3;
      set_rd(5'd0, 5'd0, 5'd0);
      tick(); idle();
      set_rd(5'd3, 5'd3, 5'd0);
      tick();
      check("mp_busy_set", DW'(rd_busy), 32'b011);

      // Async reset mid-cycle with r4 = 0xFF busy.
      wen = 1'b1; wr_addr = 5'd4; wr_data = 32'hFF;
      set_rd(5'd0, 5'd0, 5'd0);
      tick(); idle();
      iss_en = 1'b1; iss_addr = 5'd4;
      tick(); idle();
      set_rd(5'd4, 5'd4, 5'd0);
      tick();
      check("r4_pre_data", port_data(0), 32'hFF);
      check("r4_pre_busy", DW'(rd_busy[0]), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_data_p0", port_data(0), '0);
      check("async_rst_data_p1", port_data(1), '0);
      check("async_rst_busy", DW'(rd_busy), 0);
      rst_n = 1'b1;
      tick();
      check("r4_post_data", port_data(0), '0);
      check("r4_post_busy", DW'(rd_busy[0]), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
